// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider.
//   DATA_W        : operand width; quotient and remainder are DATA_W bits each
//   CNT_W         : width of the iteration counter (must hold DATA_W)
//   div_state_e   : divider FSM encoding
//   DIV_* / RST_* : handshake levels and the reset-asserted level
//   abs_if_signed : magnitude of an operand when it is treated as signed
package div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic RST_ENABLE           = 1'b0;

  function automatic logic [DATA_W-1:0] abs_if_signed(input logic [DATA_W-1:0] v,
                                                      input logic              sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Divide handshake between the EX stage (master) and div_unit (slave).
//   signed_div_i : 1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held until ready_o is seen
//   annul_i      : cancel an in-flight divide
//   result_o     : {remainder, quotient}
//   ready_o      : result_o is valid
interface div_unit_if;
  import div_unit_pkg::*;

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per clock.
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active low
//   div_bus : slave side of the divide handshake (operands, start/annul in;
//             {remainder, quotient} and ready out)
// A normal divide returns ready_o after 34 edges counting the accepting edge;
// divide by zero returns zero after 3 edges.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  div_bus
);

  div_state_e            state, state_n;
  logic [2*DATA_W:0]     dividend, dividend_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_W-1:0]     divisor, divisor_n;
  logic                  is_signed, is_signed_n;
  logic                  op1_neg, op1_neg_n;
  logic                  op2_neg, op2_neg_n;
  logic [2*DATA_W-1:0]   result_q, result_n;
  logic                  ready_q, ready_n;

  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quot_c;
  logic [DATA_W-1:0]     rem_c;

  // Partial remainder (upper half of the work register) minus divisor;
  // bit DATA_W set means the trial subtraction went negative.
  assign diff = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

  // Final sign fix-up: quotient takes the XOR of operand signs,
  // remainder takes the dividend sign.
  assign quot_c = (is_signed && (op1_neg ^ op2_neg)) ? -dividend[DATA_W-1:0]
                                                     :  dividend[DATA_W-1:0];
  assign rem_c  = (is_signed && op1_neg) ? -dividend[2*DATA_W:DATA_W+1]
                                         :  dividend[2*DATA_W:DATA_W+1];

  always_comb begin
    state_n     = state;
    dividend_n  = dividend;
    cnt_n       = cnt;
    divisor_n   = divisor;
    is_signed_n = is_signed;
    op1_neg_n   = op1_neg;
    op2_neg_n   = op2_neg;
    result_n    = result_q;
    ready_n     = ready_q;

    unique case (state)
      DIV_FREE: begin
        result_n = '0;
        ready_n  = DIV_RESULT_NOT_READY;
        if (div_bus.start_i == DIV_START && !div_bus.annul_i) begin
          if (div_bus.opdata2_i == '0) begin
            state_n = DIV_BY_ZERO;
          end else begin
            is_signed_n = div_bus.signed_div_i;
            op1_neg_n   = div_bus.signed_div_i & div_bus.opdata1_i[DATA_W-1];
            op2_neg_n   = div_bus.signed_div_i & div_bus.opdata2_i[DATA_W-1];
            divisor_n   = abs_if_signed(div_bus.opdata2_i, div_bus.signed_div_i);
            dividend_n  = {{DATA_W{1'b0}},
                           abs_if_signed(div_bus.opdata1_i, div_bus.signed_div_i),
                           1'b0};
            cnt_n       = '0;
            state_n     = DIV_ON;
          end
        end
      end

      DIV_BY_ZERO: begin
        dividend_n = '0;
        state_n    = DIV_END;
      end

      DIV_ON: begin
        if (div_bus.annul_i) begin
          state_n = DIV_FREE;
        end else if (cnt != CNT_W'(DATA_W)) begin
          if (diff[DATA_W]) begin
            dividend_n = {dividend[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_n = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
          end
          cnt_n = cnt + CNT_W'(1);
        end else begin
          // Corrected values are written back into the work register so
          // DIV_END can keep re-registering them while start_i is held.
          dividend_n = {rem_c, 1'b0, quot_c};
          result_n   = {rem_c, quot_c};
          ready_n    = DIV_RESULT_READY;
          state_n    = DIV_END;
        end
      end

      DIV_END: begin
        if (div_bus.start_i == DIV_STOP) begin
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
          state_n  = DIV_FREE;
        end else begin
          result_n = {dividend[2*DATA_W:DATA_W+1], dividend[DATA_W-1:0]};
          ready_n  = DIV_RESULT_READY;
        end
      end

      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= DIV_FREE;
      dividend  <= '0;
      cnt       <= '0;
      divisor   <= '0;
      is_signed <= 1'b0;
      op1_neg   <= 1'b0;
      op2_neg   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state     <= state_n;
      dividend  <= dividend_n;
      cnt       <= cnt_n;
      divisor   <= divisor_n;
      is_signed <= is_signed_n;
      op1_neg   <= op1_neg_n;
      op2_neg   <= op2_neg_n;
      result_q  <= result_n;
      ready_q   <= ready_n;
    end
  end

  assign div_bus.result_o = result_q;
  assign div_bus.ready_o  = ready_q;

endmodule
